test_pattern_gen: RTL and testbench

//  Pixel source fed by display_timings; produces 24-bit RGB test patterns for the video output encoder.
//  - Consumes sync, DE, frame-start and pixel position.
//  - Outputs registered RGB plus syncs and DE delayed to match.
//  - Pattern changes only at frame start. A bouncing box animates once per frame.

---
 rtl/test_pattern_gen.sv | 211 +++++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// Two-stage RGB test pattern source (colour bars, checkerboard, grey ramp, bouncing box).
// Define TEST_PATTERN_BORDER_EN to overlay a red one-pixel frame border on every pattern.
module test_pattern_gen #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int CHECK_LOG2  = 4,
  parameter int BOX_SIZE    = 32,
  parameter int BOX_SPEED   = 2,
  parameter int AUTO_FRAMES = 120
) (
  input  logic        i_pixclk,
  input  logic        i_rst,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic        i_frame,
  input  logic [12:0] i_h,
  input  logic [12:0] i_v,
  input  logic [1:0]  i_pattern,
  input  logic        i_auto,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [7:0]  o_r,
  output logic [7:0]  o_g,
  output logic [7:0]  o_b,
  output logic [1:0]  o_pattern
);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [12:0] pos;
    logic        fwd;
  } axis_t;

  localparam int          BAR_W    = H_RES / 8;
  localparam int          CNT_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);
  localparam logic [12:0] X_MAX    = 13'(H_RES - BOX_SIZE);
  localparam logic [12:0] Y_MAX    = 13'(V_RES - BOX_SIZE);
  localparam logic [12:0] STEP     = 13'(BOX_SPEED);
  localparam logic [12:0] BOX_W    = 13'(BOX_SIZE);

  // Bound is tested before stepping so the subtract can never wrap below zero.
  function automatic axis_t step_axis(input axis_t a, input logic [12:0] lim);
    axis_t n;
    n = a;
    if (a.fwd) begin
      if (a.pos >= lim - STEP) begin
        n.pos = lim;
        n.fwd = 1'b0;
      end else begin
        n.pos = a.pos + STEP;
      end
    end else begin
      if (a.pos <= STEP) begin
        n.pos = '0;
        n.fwd = 1'b1;
      end else begin
        n.pos = a.pos - STEP;
      end
    end
    return n;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Frame-rate state
  pattern_e         pattern_q, pattern_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  axis_t            box_x_q, box_x_d, box_y_q, box_y_d;

  // Stage 1
  logic       hs1_q, vs1_q, de1_q;
  pattern_e   pat1_q;
  logic [2:0] bar1_q, bar_d;
  logic       chk1_q, chk_d;
  logic [7:0] grey1_q;
  logic       box1_q, box_d;
`ifdef TEST_PATTERN_BORDER_EN
  logic       border1_q, border_d;
`endif

  // Stage 2
  logic        hs2_q, vs2_q, de2_q;
  logic [23:0] rgb_q, rgb_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    if (!i_auto) cnt_d = '0;
    if (i_frame) begin
      box_x_d = step_axis(box_x_q, X_MAX);
      box_y_d = step_axis(box_y_q, Y_MAX);
      if (!i_auto) begin
        pattern_d = pattern_e'(i_pattern);
      end else if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        pattern_d = pattern_e'(pattern_q + 2'd1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Bar index from seven constant threshold compares instead of a divider.
  always_comb begin
    bar_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (i_h >= 13'(k * BAR_W)) bar_d = bar_d + 3'd1;
    end
    chk_d = i_h[CHECK_LOG2] ^ i_v[CHECK_LOG2];
    box_d = (i_h >= box_x_q.pos) && (i_h < box_x_q.pos + BOX_W) &&
            (i_v >= box_y_q.pos) && (i_v < box_y_q.pos + BOX_W);
`ifdef TEST_PATTERN_BORDER_EN
    border_d = (i_h == 13'd0) || (i_h == 13'(H_RES - 1)) ||
               (i_v == 13'd0) || (i_v == 13'(V_RES - 1));
`endif
  end

  always_comb begin
    rgb_d = 24'h000000;
    if (de1_q) begin
      case (pat1_q)
        PAT_BARS:  rgb_d = bar_colour(bar1_q);
        PAT_CHECK: rgb_d = chk1_q ? 24'hFFFFFF : 24'h000000;
        PAT_RAMP:  rgb_d = {grey1_q, grey1_q, grey1_q};
        default:   rgb_d = box1_q ? 24'hFFFFFF : 24'h000040;
      endcase
`ifdef TEST_PATTERN_BORDER_EN
      if (border1_q) rgb_d = 24'hFF0000;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all stages update from pre-edge values.
  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) begin
      pattern_q <= PAT_BARS;
      cnt_q     <= '0;
      box_x_q   <= '{pos: 13'd0, fwd: 1'b1};
      box_y_q   <= '{pos: 13'd0, fwd: 1'b1};
      hs1_q     <= ~H_POL;
      vs1_q     <= ~V_POL;
      de1_q     <= 1'b0;
      pat1_q    <= PAT_BARS;
      bar1_q    <= 3'd0;
      chk1_q    <= 1'b0;
      grey1_q   <= 8'd0;
      box1_q    <= 1'b0;
`ifdef TEST_PATTERN_BORDER_EN
      border1_q <= 1'b0;
`endif
      hs2_q     <= ~H_POL;
      vs2_q     <= ~V_POL;
      de2_q     <= 1'b0;
      rgb_q     <= 24'h000000;
    end else begin
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      hs1_q     <= i_hs;
      vs1_q     <= i_vs;
      de1_q     <= i_de;
      pat1_q    <= pattern_q;
      bar1_q    <= bar_d;
      chk1_q    <= chk_d;
      grey1_q   <= i_h[7:0];
      box1_q    <= box_d;
`ifdef TEST_PATTERN_BORDER_EN
      border1_q <= border_d;
`endif
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      de2_q     <= de1_q;
      rgb_q     <= rgb_d;
    end
  end

  assign o_hs      = hs2_q;
  assign o_vs      = vs2_q;
  assign o_de      = de2_q;
  assign o_r       = rgb_q[23:16];
  assign o_g       = rgb_q[15:8];
  assign o_b       = rgb_q[7:0];
  assign o_pattern = pattern_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: reset, bars, pattern switching, auto-cycle, box motion, async reset.
module tb_test_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, de, frame, auto_en;
  logic [12:0] h, v;
  logic [1:0]  pat_sel;
  logic        o_hs, o_vs, o_de;
  logic [7:0]  o_r, o_g, o_b;
  logic [1:0]  o_pattern;

  int n_cmp = 0;
  int n_err = 0;

  test_pattern_gen #(
    .H_RES(640), .V_RES(480), .H_POL(1'b0), .V_POL(1'b0), .CHECK_LOG2(4),
    .BOX_SIZE(32), .BOX_SPEED(2), .AUTO_FRAMES(2)
  ) dut (
    .i_pixclk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
    .i_h(h), .i_v(v), .i_pattern(pat_sel), .i_auto(auto_en),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_pattern(o_pattern)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one active pixel, check RGB two clocks later, then return to blanking.
  task automatic pix(input string tag, input logic [12:0] px, input logic [12:0] py,
                     input logic [23:0] exp);
    h = px; v = py; de = 1'b1;
    tick();
    tick();
    check(tag, {8'h0, o_r, o_g, o_b}, {8'h0, exp});
    h = '0; v = '0; de = 1'b0;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  logic [1:0] auto_seq [9];

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; de = 1'b0; frame = 1'b0;
    h = '0; v = '0; pat_sel = 2'd0; auto_en = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      #3; hs = ~hs; vs = ~vs; de = ~de; h = 13'(i * 100);
      tick();
    end
    hs = 1'b0; vs = 1'b0; de = 1'b1;
    tick();
    check("rst_hs", 32'(o_hs), 32'd1);
    check("rst_vs", 32'(o_vs), 32'd1);
    check("rst_de", 32'(o_de), 32'd0);
    check("rst_rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
    check("rst_pat", 32'(o_pattern), 32'd0);

    // Release: outputs follow inputs after exactly two clocks
    hs = 1'b1; vs = 1'b1; de = 1'b0; h = '0;
    rst = 1'b0;
    tick(); tick(); tick();
    hs = 1'b0; vs = 1'b0;
    tick();
    check("lat1_hs", 32'(o_hs), 32'd1);
    tick();
    check("lat2_hs", 32'(o_hs), 32'd0);
    check("lat2_vs", 32'(o_vs), 32'd0);
    hs = 1'b1; vs = 1'b1;
    tick(); tick();

    // Colour bars
    pix("bar_79",  13'd79,  13'd5, 24'hFFFFFF);
    pix("bar_80",  13'd80,  13'd5, 24'hFFFF00);
    pix("bar_320", 13'd320, 13'd5, 24'hFF00FF);
    pix("bar_639", 13'd639, 13'd5, 24'h000000);
    h = 13'd100; de = 1'b0;
    tick(); tick();
    check("blank_rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
    h = '0;

    // Mid-frame pattern change waits for the frame strobe
    pat_sel = 2'd1;
    tick();
    check("hold_pat", 32'(o_pattern), 32'd0);
    pix("hold_bar", 13'd80, 13'd0, 24'hFFFF00);
    frame_pulse();
    check("load_pat", 32'(o_pattern), 32'd1);
    pix("chk_16_0",  13'd16, 13'd0,  24'hFFFFFF);
    pix("chk_0_0",   13'd0,  13'd0,  24'h000000);
    pix("chk_16_16", 13'd16, 13'd16, 24'h000000);

    // Auto-cycle with AUTO_FRAMES=2
    rst = 1'b1; tick(); rst = 1'b0; tick();
    auto_en = 1'b1; pat_sel = 2'd2;
    auto_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("auto_%0d", i), 32'(o_pattern), 32'(auto_seq[i]));
      frame_pulse();
    end
    auto_en = 1'b0;

    // Bouncing box: after n frames x=2n up to 608, y=2n up to 448 then back down
    rst = 1'b1; tick(); rst = 1'b0; tick();
    pat_sel = 2'd3;
    frame_pulse();
    check("box_pat", 32'(o_pattern), 32'd3);
    pix("box1_in",    13'd2,  13'd2,  24'hFFFFFF);
    pix("box1_left",  13'd1,  13'd2,  24'h000040);
    pix("box1_far",   13'd33, 13'd33, 24'hFFFFFF);
    pix("box1_right", 13'd34, 13'd2,  24'h000040);
    pix("box1_below", 13'd2,  13'd34, 24'h000040);
    for (int i = 0; i < 303; i++) frame_pulse();
    pix("box304_in",    13'd608, 13'd288, 24'hFFFFFF);
    pix("box304_far",   13'd639, 13'd319, 24'hFFFFFF);
    pix("box304_left",  13'd607, 13'd288, 24'h000040);
    pix("box304_below", 13'd608, 13'd320, 24'h000040);
    frame_pulse();
    pix("box305_in",    13'd606, 13'd286, 24'hFFFFFF);
    pix("box305_left",  13'd605, 13'd286, 24'h000040);
    pix("box305_right", 13'd638, 13'd286, 24'h000040);
    pix("box305_above", 13'd606, 13'd285, 24'h000040);

    // Asynchronous reset in the middle of an active line
    h = 13'd606; v = 13'd286; de = 1'b1; hs = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_de", 32'(o_de), 32'd1);
    check("pre_rst_rgb", {8'h0, o_r, o_g, o_b}, 32'h00FFFFFF);
    #2 rst = 1'b1;
    #1;
    check("async_de", 32'(o_de), 32'd0);
    check("async_rgb", {8'h0, o_r, o_g, o_b}, 32'h0);
    check("async_hs", 32'(o_hs), 32'd1);
    check("async_pat", 32'(o_pattern), 32'd0);
    de = 1'b0; h = '0; v = '0; hs = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    frame_pulse();
    pix("rst_box_in",   13'd2, 13'd2, 24'hFFFFFF);
    pix("rst_box_left", 13'd1, 13'd2, 24'h000040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
